// File: rtl/lfsr_uart_streamer.sv
// lfsr_uart_streamer
//   A WIDTH-bit Galois LFSR feeds an 8N1 UART transmitter. Each burst of
//   burst_len_i words is started with a one-cycle start_i pulse. Every word
//   is sent as WIDTH/8 bytes, least significant byte first. The LFSR steps
//   once per word and does not free-run.
//   Optional build macro: PARITY_EN adds an even-parity bit (8E1 frames).
//
// Ports
//   clk_i          system clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   seed_en_i      load seed_i into the LFSR (IDLE only; 0 becomes 1)
//   seed_i         seed value
//   start_i        one-cycle pulse, begin a burst (IDLE only, burst_len_i != 0)
//   burst_len_i    words per burst, sampled with start_i
//   abort_i        stop after the byte currently in flight
//   txd_o          UART serial output, idle high
//   busy_o         high from accepted start until return to IDLE
//   done_o         one-cycle pulse after the last stop bit of a full burst
//   rand_out_o     word currently being transmitted
//   period_flag_o  sticky, LFSR came back to the loaded seed
//
// States
//   IDLE      | waiting for seed load or start
//   LOAD      | step LFSR, capture new word, select byte 0
//   START_BIT | txd low for one bit time
//   DATA      | 8 data bits, LSB first
//   PARITY    | even parity bit (PARITY_EN builds only)
//   STOP_BIT  | txd high for one bit time
//   NEXT      | pick next byte / next word / finish / abort
module lfsr_uart_streamer #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'hB8),
  parameter int unsigned      CLKS_PER_BIT = 10416,
  parameter int unsigned      BURST_W      = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               seed_en_i,
  input  logic [WIDTH-1:0]   seed_i,
  input  logic               start_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               abort_i,
  output logic               txd_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   rand_out_o,
  output logic               period_flag_o
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_TC   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   seed_reg_q, seed_reg_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [WIDTH-1:0]   rand_q, rand_d;
  logic [BYTE_W-1:0]  byte_idx_q, byte_idx_d;
  logic [2:0]         bit_q, bit_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BURST_W-1:0] words_q, words_d;
  logic               abort_q, abort_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               period_q, period_d;
  logic               txd_q, txd_d;

  logic [WIDTH-1:0]   lfsr_step;
  logic [WIDTH-1:0]   seed_fix;
  logic [WIDTH-1:0]   word_shift;
  logic [7:0]         cur_byte;
  logic               bit_end;

  assign lfsr_step  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  assign seed_fix   = (seed_i == '0) ? WIDTH'(1) : seed_i;
  assign word_shift = word_q >> {byte_idx_q, 3'b000};
  assign cur_byte   = word_shift[7:0];
  assign bit_end    = (baud_q == '0);

  // txd is registered from the current state, so the line lags the FSM by
  // one cycle; this gives the two-cycle start-to-start-bit latency and lets
  // reset drive the line high asynchronously.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_reg_d = seed_reg_q;
    word_d     = word_q;
    rand_d     = rand_q;
    byte_idx_d = byte_idx_q;
    bit_d      = bit_q;
    baud_d     = baud_q;
    words_d    = words_q;
    abort_d    = abort_q | (busy_q & abort_i);
    busy_d     = busy_q;
    done_d     = 1'b0;
    period_d   = period_q;
    txd_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (seed_en_i) begin
          lfsr_d     = seed_fix;
          seed_reg_d = seed_fix;
          period_d   = 1'b0;
        end
        if (start_i && (burst_len_i != '0)) begin
          words_d = burst_len_i;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        lfsr_d     = lfsr_step;
        word_d     = lfsr_step;
        rand_d     = lfsr_step;
        byte_idx_d = '0;
        baud_d     = BAUD_TC;
        if (lfsr_step == seed_reg_q) period_d = 1'b1;
        state_d    = S_START;
      end
      S_START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          baud_d  = BAUD_TC;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        txd_d = cur_byte[bit_q];
        if (bit_end) begin
          baud_d = BAUD_TC;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        txd_d = ^cur_byte;
        if (bit_end) begin
          baud_d  = BAUD_TC;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_NEXT;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_NEXT: begin
        if (abort_q || abort_i) begin
          busy_d  = 1'b0;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else if (byte_idx_q != LAST_BYTE) begin
          byte_idx_d = byte_idx_q + 1'b1;
          baud_d     = BAUD_TC;
          state_d    = S_START;
        end else if (words_q > BURST_W'(1)) begin
          words_d = words_q - 1'b1;
          state_d = S_LOAD;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      lfsr_q     <= WIDTH'(1);
      seed_reg_q <= WIDTH'(1);
      word_q     <= '0;
      rand_q     <= '0;
      byte_idx_q <= '0;
      bit_q      <= '0;
      baud_q     <= '0;
      words_q    <= '0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      period_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_reg_q <= seed_reg_d;
      word_q     <= word_d;
      rand_q     <= rand_d;
      byte_idx_q <= byte_idx_d;
      bit_q      <= bit_d;
      baud_q     <= baud_d;
      words_q    <= words_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      period_q   <= period_d;
      txd_q      <= txd_d;
    end
  end

  assign txd_o         = txd_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign rand_out_o    = rand_q;
  assign period_flag_o = period_q;

endmodule

// File: tb/tb_lfsr_uart_streamer.sv
module tb_lfsr_uart_streamer;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WORD8 = FB * CPB + 2;

  typedef struct {
    logic [7:0]  b;
    logic [31:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        seed_en8 = 0, start8 = 0, abort8 = 0;
  logic [7:0]  seed8 = 0, burst8 = 0;
  logic        txd8, busy8, done8, per8;
  logic [7:0]  rand8;

  logic        seed_en16 = 0, start16 = 0;
  logic [15:0] seed16 = 0;
  logic [7:0]  burst16 = 0;
  logic        txd16, busy16, done16, per16;
  logic [15:0] rand16;

  lfsr_uart_streamer #(.WIDTH(8), .TAPS(8'hB8), .CLKS_PER_BIT(CPB), .BURST_W(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .seed_en_i(seed_en8), .seed_i(seed8),
    .start_i(start8), .burst_len_i(burst8), .abort_i(abort8),
    .txd_o(txd8), .busy_o(busy8), .done_o(done8), .rand_out_o(rand8),
    .period_flag_o(per8));

  lfsr_uart_streamer #(.WIDTH(16), .TAPS(16'hB400), .CLKS_PER_BIT(CPB), .BURST_W(8)) dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .seed_en_i(seed_en16), .seed_i(seed16),
    .start_i(start16), .burst_len_i(burst16), .abort_i(1'b0),
    .txd_o(txd16), .busy_o(busy16), .done_o(done16), .rand_out_o(rand16),
    .period_flag_o(per16));

  int errors = 0;
  int checks = 0;
  exp_t q8[$];
  exp_t q16[$];
  bit rx_ignore = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] v, input logic [31:0] taps);
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART receivers: sample at the centre of each bit on the falling clock edge
  initial begin : rx8
    logic [7:0] b;
    logic       stopb, par;
    logic [7:0] w;
    exp_t       e;
    forever begin
      @(negedge txd8);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd8;
      end
      par = 1'b0;
`ifdef PARITY_EN
      repeat (CPB) @(negedge clk);
      par = txd8;
`endif
      repeat (CPB) @(negedge clk);
      stopb = txd8;
      w = rand8;
      if (!rx_ignore) begin
        chk("rx8_expected_byte_pending", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          chk("rx8_byte", 32'(b), 32'(e.b));
          chk("rx8_stop", 32'(stopb), 32'd1);
          chk("rx8_rand_out", 32'(w), e.w);
`ifdef PARITY_EN
          chk("rx8_parity", 32'(par), 32'(^e.b));
`endif
        end
      end
    end
  end

  initial begin : rx16
    logic [7:0] b;
    logic       stopb, par;
    logic [15:0] w;
    exp_t       e;
    forever begin
      @(negedge txd16);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd16;
      end
      par = 1'b0;
`ifdef PARITY_EN
      repeat (CPB) @(negedge clk);
      par = txd16;
`endif
      repeat (CPB) @(negedge clk);
      stopb = txd16;
      w = rand16;
      chk("rx16_expected_byte_pending", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        chk("rx16_byte", 32'(b), 32'(e.b));
        chk("rx16_stop", 32'(stopb), 32'd1);
        chk("rx16_rand_out", 32'(w), e.w);
`ifdef PARITY_EN
        chk("rx16_parity", 32'(par), 32'(^e.b));
`endif
      end
    end
  end

  initial begin : stim
    logic [31:0] m;
    int  c;
    bit  done_seen, bad;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_txd", 32'(txd8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_rand_out", 32'(rand8), 32'd0);
    chk("rst_period", 32'(per8), 32'd0);
    chk("rst_txd16", 32'(txd16), 32'd1);

    // burst of 3 from seed 1
    seed8 = 8'h01; seed_en8 = 1; tick(); seed_en8 = 0;
    m = 32'h1;
    for (int i = 0; i < 3; i++) begin
      m = step(m, 32'hB8);
      q8.push_back('{b: m[7:0], w: m});
    end
    start8 = 1; burst8 = 8'd3; tick(); start8 = 0; c = 0;
    chk("t1_busy_after_start", 32'(busy8), 32'd1);
    tick(); c++;
    chk("t1_txd_high_c1", 32'(txd8), 32'd1);
    tick(); c++;
    chk("t1_txd_low_c2", 32'(txd8), 32'd0);
    done_seen = 0;
    while (!done8 && c < 1000) begin tick(); c++; end
    chk("t1_done_cycle", 32'(c), 32'(3 * WORD8));
    chk("t1_busy_low_at_done", 32'(busy8), 32'd0);
    tick();
    chk("t1_done_one_cycle", 32'(done8), 32'd0);
    chk("t1_queue_drained", 32'(q8.size()), 32'd0);

    // seed 0 loaded together with start -> LFSR treated as 1
    seed8 = 8'h00; seed_en8 = 1; start8 = 1; burst8 = 8'd1;
    q8.push_back('{b: 8'hB8, w: 32'hB8});
    tick(); seed_en8 = 0; start8 = 0; c = 0;
    while (!done8 && c < 1000) begin tick(); c++; end
    chk("t2_done_cycle", 32'(c), 32'(WORD8));
    chk("t2_queue_drained", 32'(q8.size()), 32'd0);

    // full period: 255 words, the last one equals the seed
    seed8 = 8'h01; seed_en8 = 1; tick(); seed_en8 = 0;
    m = 32'h1;
    for (int i = 0; i < 255; i++) begin
      m = step(m, 32'hB8);
      q8.push_back('{b: m[7:0], w: m});
    end
    start8 = 1; burst8 = 8'd255; tick(); start8 = 0; c = 0;
    tick(); c++;
    chk("t4_period_low_early", 32'(per8), 32'd0);
    while (!done8 && c < 20000) begin tick(); c++; end
    chk("t4_done_cycle", 32'(c), 32'(255 * WORD8));
    chk("t4_period_high_after_done", 32'(per8), 32'd1);
    chk("t4_last_word", 32'(rand8), 32'h01);
    chk("t4_queue_drained", 32'(q8.size()), 32'd0);
    seed8 = 8'h01; seed_en8 = 1; tick(); seed_en8 = 0;
    chk("t4_period_cleared_by_seed", 32'(per8), 32'd0);

    // abort during the second word
    m = 32'h1;
    for (int i = 0; i < 2; i++) begin
      m = step(m, 32'hB8);
      q8.push_back('{b: m[7:0], w: m});
    end
    start8 = 1; burst8 = 8'd5; tick(); start8 = 0; c = 0;
    while (c < WORD8 + 20) begin tick(); c++; end
    abort8 = 1; tick(); c++; abort8 = 0;
    done_seen = 0;
    while (busy8 && c < 1000) begin
      tick(); c++;
      if (done8) done_seen = 1;
    end
    chk("t5_idle_cycle", 32'(c), 32'(2 * WORD8));
    chk("t5_no_done", 32'(done_seen | done8), 32'd0);
    repeat (3) tick();
    chk("t5_queue_drained", 32'(q8.size()), 32'd0);
    start8 = 1; burst8 = 8'd0; tick(); start8 = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy8 !== 1'b0 || txd8 !== 1'b1 || done8 !== 1'b0) bad = 1;
      tick();
    end
    chk("t5_zero_len_ignored", 32'(bad), 32'd0);

    // reset in the middle of a data bit
    seed8 = 8'h5A; seed_en8 = 1; tick(); seed_en8 = 0;
    rx_ignore = 1;
    start8 = 1; burst8 = 8'd2; tick(); start8 = 0; c = 0;
    while (c < 12) begin tick(); c++; end
    chk("t6_busy_before_reset", 32'(busy8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_txd_async_high", 32'(txd8), 32'd1);
    chk("t6_busy_async_low", 32'(busy8), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (60) tick();
    rx_ignore = 0;
    q8.push_back('{b: 8'hB8, w: 32'hB8});
    start8 = 1; burst8 = 8'd1; tick(); start8 = 0; c = 0;
    while (!done8 && c < 1000) begin tick(); c++; end
    chk("t6_done_cycle", 32'(c), 32'(WORD8));
    chk("t6_queue_drained", 32'(q8.size()), 32'd0);

    // 16-bit word split into two bytes, LSB byte first
    seed16 = 16'h0001; seed_en16 = 1; tick(); seed_en16 = 0;
    m = step(32'h1, 32'hB400);
    q16.push_back('{b: m[7:0], w: m});
    q16.push_back('{b: m[15:8], w: m});
    start16 = 1; burst16 = 8'd1; tick(); start16 = 0; c = 0;
    tick(); c++;
    chk("t3_rand_out16", 32'(rand16), 32'hB400);
    while (!done16 && c < 1000) begin tick(); c++; end
    chk("t3_done_cycle", 32'(c), 32'(1 + 2 * (FB * CPB + 1)));
    chk("t3_busy_low", 32'(busy16), 32'd0);
    chk("t3_queue_drained", 32'(q16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
